// File: rtl/div_sched_pkg.sv
// Shared constants, state encoding and result-select helper for the divide scheduler.
package div_sched_pkg;

  localparam int unsigned WORD_W            = 32;
  localparam int unsigned OP_W              = 2;
  localparam int unsigned DIV_OP_SIGNED_BIT = 0;
  localparam int unsigned DIV_OP_MOD_BIT    = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } div_state_e;

  // Operand tag identifying a cached divide result.
  typedef struct packed {
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    logic              sgn;
  } div_tag_t;

  function automatic logic [WORD_W-1:0] div_select(input logic              mod,
                                                   input logic [WORD_W-1:0] q,
                                                   input logic [WORD_W-1:0] r);
    return mod ? r : q;
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// One-entry quotient/remainder cache tagged by dividend, divisor and signedness.
module div_result_cache
  import div_sched_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              inval,
  input  logic              fill,
  input  logic [WORD_W-1:0] fill_x,
  input  logic [WORD_W-1:0] fill_y,
  input  logic              fill_signed,
  input  logic [WORD_W-1:0] fill_q,
  input  logic [WORD_W-1:0] fill_r,
  input  logic [WORD_W-1:0] look_x,
  input  logic [WORD_W-1:0] look_y,
  input  logic              look_signed,
  output logic              hit_c,
  output logic              valid,
  output logic [WORD_W-1:0] q,
  output logic [WORD_W-1:0] r
);

  div_tag_t tag_q;
  div_tag_t look_tag;
  logic     fill_en;

  assign fill_en  = fill && ENABLE;
  assign look_tag = '{x: look_x, y: look_y, sgn: look_signed};
  assign hit_c    = ENABLE && valid && (tag_q == look_tag);

  // Valid bit follows reset; payload only ever changes on a fill.
  always_ff @(posedge clk) begin
    if (inval) begin
      valid <= 1'b0;
    end else if (fill_en) begin
      valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q <= '{x: fill_x, y: fill_y, sgn: fill_signed};
      q     <= fill_q;
      r     <= fill_r;
    end
  end

endmodule

// File: rtl/div_sched.sv
// EX-stage sequencer for the shared iterative divider: accept, run or reuse, hold for MEM,
// and drain the divider on flush so its frozen counter never leaks into the next op.
module div_sched
  import div_sched_pkg::*;
#(
  parameter bit          ENABLE_CACHE = 1'b1,
  parameter int unsigned DIV_CYCLES   = 34
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [WORD_W-1:0] in_x,
  input  logic [WORD_W-1:0] in_y,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic              div_en,
  output logic              div_signed,
  output logic [WORD_W-1:0] div_x,
  output logic [WORD_W-1:0] div_y,
  input  logic [WORD_W-1:0] div_s,
  input  logic [WORD_W-1:0] div_r,
  input  logic              div_complete
);

  localparam int unsigned DivCyclesMin = 2;

  // The first-cycle complete guard only makes sense for a multi-cycle divider.
  if (DIV_CYCLES < DivCyclesMin) begin : g_div_cycles_too_small
  end

  div_state_e        state;
  logic [WORD_W-1:0] x_q;
  logic [WORD_W-1:0] y_q;
  logic              signed_q;
  logic              mod_q;
  logic              busy_first;

  logic              accept;
  logic              div_done;
  logic              cache_hit;
  logic              cache_valid;
  logic [WORD_W-1:0] cache_q;
  logic [WORD_W-1:0] cache_r;

  assign in_ready = ((state == ST_IDLE) || ((state == ST_DONE) && out_ready)) && !flush;
  assign accept   = in_valid && in_ready;

  // A complete that ends a run: never in the first BUSY cycle, only while the divider is ours.
  assign div_done = div_complete && !busy_first &&
                    ((state == ST_BUSY) || (state == ST_DRAIN));

  assign div_x      = x_q;
  assign div_y      = y_q;
  assign div_signed = signed_q;

  div_result_cache #(
    .ENABLE (ENABLE_CACHE)
  ) u_cache (
    .clk         (clk),
    .inval       (reset),
    .fill        (div_done),
    .fill_x      (x_q),
    .fill_y      (y_q),
    .fill_signed (signed_q),
    .fill_q      (div_s),
    .fill_r      (div_r),
    .look_x      (in_x),
    .look_y      (in_y),
    .look_signed (in_op[DIV_OP_SIGNED_BIT]),
    .hit_c       (cache_hit),
    .valid       (cache_valid),
    .q           (cache_q),
    .r           (cache_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      div_en     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      signed_q   <= 1'b0;
      mod_q      <= 1'b0;
      busy_first <= 1'b0;
    end else begin
      busy_first <= 1'b0;
      if (accept) begin
        x_q      <= in_x;
        y_q      <= in_y;
        signed_q <= in_op[DIV_OP_SIGNED_BIT];
        mod_q    <= in_op[DIV_OP_MOD_BIT];
        if (cache_hit) begin
          state      <= ST_DONE;
          out_valid  <= 1'b1;
          out_result <= div_select(in_op[DIV_OP_MOD_BIT], cache_q, cache_r);
          div_en     <= 1'b0;
        end else begin
          state      <= ST_BUSY;
          out_valid  <= 1'b0;
          div_en     <= 1'b1;
          busy_first <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
          end
          ST_BUSY: begin
            if (div_done) begin
              div_en <= 1'b0;
              if (flush) begin
                state <= ST_IDLE;
              end else begin
                state      <= ST_DONE;
                out_valid  <= 1'b1;
                out_result <= div_select(mod_q, div_s, div_r);
              end
            end else if (flush) begin
              state <= ST_DRAIN;
            end
          end
          ST_DONE: begin
            if (flush || out_ready) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
            end
          end
          ST_DRAIN: begin
            // Keep div high until the divider finishes so its counter returns to zero.
            if (div_done) begin
              div_en <= 1'b0;
              state  <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
